ram_pipeline_dual_read: RTL and testbench
=========================================

# ram_pipeline_dual_read

1024 x 16 single-clock RAM with one write/read port (port 1) and one read-only port (port 2). Each read path has two register stages: a RAM output register and a pipeline output register, for a 2-cycle read latency. The block is the registered-read memory primitive for datapaths that need inference-friendly BRAM mapping with output pipelining.

## Interface
- DATA_W, 16, word width
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W = 1024 words
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset; clears pipeline registers only
- we  in  1  write enable for port 1; qualified by en1
- en1  in  1  port-1 enable; gates the write, the port-1 RAM output register and the res1 register
- en2  in  1  port-2 enable; gates the port-2 RAM output register and the res2 register
- addr1  in  ADDR_W  port-1 address, used for write and read
- addr2  in  ADDR_W  port-2 read address
- di  in  DATA_W  write data
- res1  out  DATA_W  port-1 pipelined read data
- res2  out  DATA_W  port-2 pipelined read data

## Operation
- Storage: mem[0:DEPTH-1] of DATA_W bits.
  - Not reset.
  - Contents are unspecified until written.
- Port 1, on each clk edge with en1=1:
  - If we=1: mem[addr1] <= di.
  - do1 <= mem[addr1], read-first: do1 gets the old word, not di.
  - res1 <= do1.
- Port 2, on each clk edge with en2=1:
  - do2 <= mem[addr2].
  - res2 <= do2.
- Port enable low: both registers of that port hold their value. With en1=0, we has no effect and mem is not written.
- Same-address collision: port 2 reading addr1 while port 1 writes it returns the old word. The new word is visible from the next edge.
- Address range: addresses are full-range; no out-of-range case exists, and there is no wrap logic.
- rst=1 clears do1, do2, res1 and res2 to 0 immediately (asynchronous) and holds them at 0 while asserted.
  - Memory contents are preserved across reset.
  - Writes are blocked while rst=1.

## Timing
- Read latency is 2 enabled edges.
  - Address A presented with en=1 before edge N: the word appears on res at edge N+1, provided en is also 1 at edge N+1.
- Pipeline stalls whenever en is 0; stages advance together, and no bubble is inserted.
- Write takes effect at the edge it is sampled on. A port-1 read of the same address at edge N+1 returns the new data on res1 after edge N+2.
- Reset values: res1 = 0, res2 = 0.
- Release of rst is synchronous to the next clk edge. The first valid read data appears 2 enabled edges after release.
- Outputs are registered; there is no combinational path from inputs to res1/res2.

## Structure
- Shared package ram_pipe_pkg:
  - DATA_W and ADDR_W defaults.
  - DEPTH localparam.
  - Typedefs word_t and addr_t.
- Top level: memory array plus write logic, written in BRAM-inferable form. It contains one synchronous read per port and no reset on the array.
- Sub-module ram_rd_pipe:
  - Contains the two-stage enable-gated register pair (do -> res) with async reset.
  - Instantiated once per port.

## Test plan
- Fill: 1024 edges with en1=en2=1, we=1, addr1=0..1023, di random, addr2 random. Then read addr1=addr2=i with we=0 → res1 and res2 equal the written di for addr i, 2 edges after each address.
- Latency: write mem[5]=16'hA5A5, then read addr2=5 → res2 stays at the prior value for 1 edge and equals 16'hA5A5 after the 2nd edge.
- Enable hold: with en1=en2=0, sweep addresses and toggle we=1 with di=16'hFFFF → res1/res2 frozen, and a later read shows memory unchanged.
- Collision: mem[7]=16'h1111; write 16'h2222 to addr1=7 while addr2=7 → res2 returns 16'h1111, and the next read returns 16'h2222. Port 1 behaves read-first the same way.
- Reset mid-stream: assert rst between edges during back-to-back reads → res1=res2=0 immediately, mem[3] is still intact after release, and reads resume with 2-edge latency.
- Random: 1024 edges of random en1, en2, we, addr1, addr2, di, compared against a cycle-accurate reference model → zero mismatches.

Source files
------------

// File: rtl/ram_pipe_pkg.sv
// Shared widths and types for the dual-read pipelined RAM.
// Imported by the RAM top level and its read-pipeline stage.
package ram_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Two-stage enable-gated read pipeline: RAM output register then result register.
// Both stages advance together on en and clear asynchronously on rst.
module ram_rd_pipe
    import ram_pipe_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] rd,
    output logic [W-1:0] res
);

    logic [W-1:0] do_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q <= '0;
            res  <= '0;
        end else if (en) begin
            do_q <= rd;
            res  <= do_q;
        end
    end

endmodule

// File: rtl/ram_pipeline_dual_read.sv
// 1024x16 single-clock RAM: port 1 read-first write/read, port 2 read-only.
// Each read path is registered twice for a 2-cycle latency.
module ram_pipeline_dual_read
    import ram_pipe_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                en1,
    input  logic                en2,
    input  logic [ADDR_W_P-1:0] addr1,
    input  logic [ADDR_W_P-1:0] addr2,
    input  logic [DATA_W_P-1:0] di,
    output logic [DATA_W_P-1:0] res1,
    output logic [DATA_W_P-1:0] res2
);

    localparam int DEPTH_P = 1 << ADDR_W_P;

    logic [DATA_W_P-1:0] mem [DEPTH_P];
    logic [DATA_W_P-1:0] rd1;
    logic [DATA_W_P-1:0] rd2;

    // No reset on the array so it maps onto block RAM; writes held off during rst.
    always_ff @(posedge clk) begin
        if (en1 && we && !rst) begin
            mem[addr1] <= di;
        end
    end

    // Sampled by the first pipeline register, so both ports see the pre-write word.
    assign rd1 = mem[addr1];
    assign rd2 = mem[addr2];

    ram_rd_pipe #(.W(DATA_W_P)) u_pipe1 (
        .clk (clk),
        .rst (rst),
        .en  (en1),
        .rd  (rd1),
        .res (res1)
    );

    ram_rd_pipe #(.W(DATA_W_P)) u_pipe2 (
        .clk (clk),
        .rst (rst),
        .en  (en2),
        .rd  (rd2),
        .res (res2)
    );

endmodule

// File: tb/tb_ram_pipeline_dual_read.sv
// Directed, table-driven and model-based bench for ram_pipeline_dual_read.
// Inputs change just after rising edges; outputs are compared 1 ns after each edge.
module tb_ram_pipeline_dual_read;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic [9:0]  addr1 = '0;
    logic [9:0]  addr2 = '0;
    logic [15:0] di = '0;
    logic [15:0] res1;
    logic [15:0] res2;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mm [1024];
    logic [15:0] fill [1024];
    logic [15:0] m_do1 = '0;
    logic [15:0] m_do2 = '0;
    logic [15:0] m_res1 = '0;
    logic [15:0] m_res2 = '0;

    typedef struct {
        logic        en1;
        logic        en2;
        logic        we;
        logic [9:0]  a1;
        logic [9:0]  a2;
        logic [15:0] di;
        logic        c1;
        logic [15:0] e1;
        logic        c2;
        logic [15:0] e2;
    } vec_t;

    vec_t tv [11];

    ram_pipeline_dual_read dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .en1   (en1),
        .en2   (en2),
        .addr1 (addr1),
        .addr2 (addr2),
        .di    (di),
        .res1  (res1),
        .res2  (res2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic e1en, input logic e2en,
                                input logic w, input logic [9:0] a1,
                                input logic [9:0] a2, input logic [15:0] d,
                                input logic c1, input logic [15:0] x1,
                                input logic c2, input logic [15:0] x2);
        vec_t v;
        v.en1 = e1en; v.en2 = e2en; v.we = w;
        v.a1 = a1; v.a2 = a2; v.di = d;
        v.c1 = c1; v.e1 = x1; v.c2 = c2; v.e2 = x2;
        return v;
    endfunction

    task automatic model_reset();
        m_do1 = '0; m_do2 = '0; m_res1 = '0; m_res2 = '0;
    endtask

    // One rising edge: advance the reference model, then settle 1 ns.
    task automatic step();
        logic [15:0] r1;
        logic [15:0] r2;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            r1 = mm[addr1];
            r2 = mm[addr2];
            if (en1) begin
                m_res1 = m_do1;
                m_do1 = r1;
                if (we) mm[addr1] = di;
            end
            if (en2) begin
                m_res2 = m_do2;
                m_do2 = r2;
            end
        end
        #1;
    endtask

    initial begin
        // Hand-computed sequence starting from a fresh reset (all pipe regs 0).
        tv[0]  = mk(1, 0, 1, 5, 0, 16'hA5A5, 1, 16'h0000, 1, 16'h0000);
        tv[1]  = mk(1, 0, 1, 7, 0, 16'h1111, 0, 16'h0000, 1, 16'h0000);
        tv[2]  = mk(1, 1, 1, 3, 5, 16'h3333, 0, 16'h0000, 1, 16'h0000);
        tv[3]  = mk(1, 1, 1, 7, 7, 16'h2222, 0, 16'h0000, 1, 16'hA5A5);
        tv[4]  = mk(1, 1, 0, 7, 7, 16'h0000, 1, 16'h1111, 1, 16'h1111);
        tv[5]  = mk(1, 1, 0, 5, 3, 16'h0000, 1, 16'h2222, 1, 16'h2222);
        tv[6]  = mk(0, 0, 1, 5, 0, 16'hFFFF, 1, 16'h2222, 1, 16'h2222);
        tv[7]  = mk(0, 0, 1, 3, 9, 16'hFFFF, 1, 16'h2222, 1, 16'h2222);
        tv[8]  = mk(1, 1, 0, 3, 5, 16'h0000, 1, 16'hA5A5, 1, 16'h3333);
        tv[9]  = mk(1, 1, 0, 3, 5, 16'h0000, 1, 16'h3333, 1, 16'hA5A5);
        tv[10] = mk(0, 1, 1, 9, 5, 16'hFFFF, 1, 16'h3333, 1, 16'hA5A5);

        for (int i = 0; i < 1024; i++) mm[i] = '0;

        // Reset state, with clocks running and enables high.
        en1 = 1'b1; en2 = 1'b1;
        #22;
        chk("reset_res1", res1, 16'h0000);
        chk("reset_res2", res2, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Fill every word through port 1.
        for (int i = 0; i < 1024; i++) begin
            en1 = 1'b1; en2 = 1'b1; we = 1'b1;
            addr1 = 10'(i);
            addr2 = 10'($urandom_range(1023));
            di = 16'($urandom);
            fill[i] = di;
            step();
        end

        // Read back on both ports; data for address k-1 lands after edge k.
        for (int k = 0; k < 1026; k++) begin
            we = 1'b0;
            addr1 = (k < 1024) ? 10'(k) : 10'd0;
            addr2 = addr1;
            step();
            if (k >= 1 && k <= 1024) begin
                chk("fill_res1", res1, fill[k-1]);
                chk("fill_res2", res2, fill[k-1]);
            end
        end

        // Fresh reset so the directed table starts from zeroed pipelines.
        en1 = 1'b0; en2 = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst2_res1", res1, 16'h0000);
        chk("rst2_res2", res2, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Latency, collision, read-first and enable-hold vectors.
        for (int i = 0; i < 11; i++) begin
            en1 = tv[i].en1; en2 = tv[i].en2; we = tv[i].we;
            addr1 = tv[i].a1; addr2 = tv[i].a2; di = tv[i].di;
            step();
            if (tv[i].c1) chk($sformatf("tv%0d_res1", i), res1, tv[i].e1);
            if (tv[i].c2) chk($sformatf("tv%0d_res2", i), res2, tv[i].e2);
        end

        // Reset in the middle of back-to-back reads of address 3.
        en1 = 1'b1; en2 = 1'b1; we = 1'b0;
        addr1 = 10'd3; addr2 = 10'd3;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_res1", res1, 16'h3333);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_res1", res1, 16'h0000);
        chk("async_rst_res2", res2, 16'h0000);
        we = 1'b1; di = 16'hDEAD;
        step();
        chk("rst_hold_res1", res1, 16'h0000);
        chk("rst_hold_res2", res2, 16'h0000);
        #2;
        rst = 1'b0;
        we = 1'b0;
        step();
        chk("rel1_res1", res1, 16'h0000);
        chk("rel1_res2", res2, 16'h0000);
        step();
        chk("rel2_res1", res1, 16'h3333);
        chk("rel2_res2", res2, 16'h3333);

        // Random traffic against the reference model.
        for (int i = 0; i < 1024; i++) begin
            en1 = 1'($urandom);
            en2 = 1'($urandom);
            we = 1'($urandom);
            addr1 = 10'($urandom_range(15));
            addr2 = 10'($urandom_range(15));
            di = 16'($urandom);
            step();
            chk("rand_res1", res1, m_res1);
            chk("rand_res2", res2, m_res2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
